// File: rtl/dmem_pkg.sv
// Shared FSM states, access-size codes and alignment helper for the data-memory responder.
// Latency: none, purely combinational helpers and constants.
// Backpressure: not applicable, no handshakes live here.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // An access of 1<<size bytes must start on a multiple of its own size.
    function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = |addr_lo[1:0];
            default: bad = |addr_lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Backing word store for the responder: DEPTH x XLEN, byte-enabled write port.
// Latency: combinational read, write lands on the next rising edge.
// Backpressure: none, the responder serialises every access.
module dmem_array #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN/8-1:0] i_wstrb,
    output logic [XLEN-1:0]   o_rdata
);

    logic [XLEN-1:0] r_mem [DEPTH];

    // Byte-lane write: lanes with a clear strobe keep their old contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < XLEN/8; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read is asynchronous so the pre-store word can be captured on the write edge.
    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LAT wait cycles, then a held response.
// Latency: rsp_valid is first seen LAT+1 cycles after the accept edge; one request per LAT+2 cycles.
// Backpressure: req_ready drops from accept until the response handshake; the response holds while rsp_ready is low.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int              XLEN  = 64,
    parameter int              DEPTH = 4096,
    parameter logic [XLEN-1:0] BASE  = 64'h8000_0000,
    parameter int              LAT   = 2
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic              i_req_wen,
    input  logic [1:0]        i_req_size,
    input  logic [XLEN-1:0]   i_req_wdata,
    input  logic [XLEN/8-1:0] i_req_wstrb,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_err
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic            LAT_ZERO = (LAT == 0);
    localparam logic [3:0]      LAT_M1   = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
    localparam logic [XLEN-1:0] DEPTH_W  = XLEN'(DEPTH);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [XLEN-1:0]     r_addr;
    logic                r_wen;
    logic [1:0]          r_size;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN/8-1:0]   r_wstrb;
    logic [XLEN-1:0]     r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_idle;
    logic                w_accept;
    logic                w_exec;
    logic                w_we;
    logic                w_err;
    logic [XLEN-1:0]     w_addr;
    logic                w_wen;
    logic [1:0]          w_size;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN/8-1:0]   w_wstrb;
    logic [XLEN-1:0]     w_off;
    logic [AW-1:0]       w_idx;
    logic [XLEN-1:0]     w_rdata;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = i_req_valid && w_idle;

    // With LAT=0 the access runs on the accept edge itself, so it must see the live
    // request; otherwise it uses the copy captured at accept.
    assign w_addr  = w_idle ? i_req_addr  : r_addr;
    assign w_wen   = w_idle ? i_req_wen   : r_wen;
    assign w_size  = w_idle ? i_req_size  : r_size;
    assign w_wdata = w_idle ? i_req_wdata : r_wdata;
    assign w_wstrb = w_idle ? i_req_wstrb : r_wstrb;

    // Below BASE wraps the offset, so that case is caught by the first term.
    assign w_off = w_addr - BASE;
    assign w_idx = w_off[AW+2:3];
    assign w_err = (w_addr < BASE) || ((w_off >> 3) >= DEPTH_W) || misaligned(w_addr[2:0], w_size);

    // The access executes on the edge that enters RESP; reset on that edge discards it.
    assign w_exec = !i_rst && ((w_accept && LAT_ZERO) || ((r_state == ST_WAIT) && (r_cnt == 4'd0)));
    assign w_we   = w_exec && w_wen && !w_err;

    dmem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb),
        .o_rdata (w_rdata)
    );

    // Control FSM plus the response registers, which only change on access execution.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= LAT_ZERO ? ST_RESP : ST_WAIT;
                        r_cnt   <= LAT_M1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_exec) begin
                r_rsp_rdata <= w_err ? '0 : w_rdata;
                r_rsp_err   <= w_err;
            end
        end
    end

    // Capture the request payload on accept; it is pure data, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_addr  <= i_req_addr;
            r_wen   <= i_req_wen;
            r_size  <= i_req_size;
            r_wdata <= i_req_wdata;
            r_wstrb <= i_req_wstrb;
        end
    end

    assign o_req_ready = w_idle;
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (LAT=2 and LAT=0) share one request bus, selected by sel.
// Latency: expectations carry the accept cycle so the monitor checks response timing.
// Backpressure: rsp_ready is held high, held low, or randomised depending on the phase.
module tb_dmem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        logic        known;
        logic [31:0] acc;
        logic [31:0] lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_ready = 1'b1;

    logic        rdy2, rdy0, val2, val0, er2, er0;
    logic [63:0] rd2, rd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rdy_mode = 1;
    int          last_hs  = -100;
    logic [63:0] last_rdata = '0;
    logic        last_err   = 1'b0;

    exp_t        exp_q[$];
    logic [63:0] mem_l2 [logic [63:0]];
    logic [63:0] mem_l0 [logic [63:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.XLEN(64), .DEPTH(DEPTH), .BASE(BASE), .LAT(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && !sel), .o_req_ready(rdy2),
        .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_size(req_size),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb), .o_rsp_valid(val2),
        .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd2), .o_rsp_err(er2)
    );

    dmem_responder #(.XLEN(64), .DEPTH(DEPTH), .BASE(BASE), .LAT(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid && sel), .o_req_ready(rdy0),
        .i_req_addr(req_addr), .i_req_wen(req_wen), .i_req_size(req_size),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb), .o_rsp_valid(val0),
        .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd0), .o_rsp_err(er0)
    );

    assign req_ready = sel ? rdy0 : rdy2;
    assign rsp_valid = sel ? val0 : val2;
    assign rsp_rdata = sel ? rd0  : rd2;
    assign rsp_err   = sel ? er0  : er2;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference memory: range, alignment and strobe rules in plain arithmetic.
    function automatic exp_t model_access(input logic [63:0] a, input logic w, input logic [1:0] sz,
                                          input logic [63:0] wd, input logic [7:0] ws);
        exp_t        e;
        logic [63:0] wa, old, nw;
        bit          have;
        e.acc = '0;
        e.lat = sel ? 32'd0 : 32'd2;
        e.err = (a < BASE) || (a >= BASE + 64'(DEPTH) * 64'd8) || ((a % (64'd1 << sz)) != 64'd0);
        if (e.err) begin
            e.rdata = '0;
            e.known = 1'b1;
            return e;
        end
        wa   = {a[63:3], 3'b000};
        have = sel ? mem_l0.exists(wa) : mem_l2.exists(wa);
        old  = have ? (sel ? mem_l0[wa] : mem_l2[wa]) : 64'd0;
        e.rdata = old;
        e.known = have;
        if (w && (have || ws == 8'hFF)) begin
            nw = old;
            for (int i = 0; i < 8; i++) begin
                if (ws[i]) nw[8*i +: 8] = wd[8*i +: 8];
            end
            if (sel) mem_l0[wa] = nw;
            else     mem_l2[wa] = nw;
        end
        return e;
    endfunction

    // rsp_ready is driven just after the falling edge so phase changes land deterministically.
    always @(negedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: checks hold stability, timing and data of every response against the queue.
    logic        p_valid = 1'b0, p_ready = 1'b0, p_err = 1'b0;
    logic [63:0] p_rdata = '0;
    always @(negedge clk) begin : mon
        exp_t e;
        #2;
        if (!rst) begin
            if (p_valid && !p_ready) begin
                check64("rsp_hold_valid", {63'd0, rsp_valid}, 64'd1);
                if (rsp_valid) begin
                    check64("rsp_hold_rdata", rsp_rdata, p_rdata);
                    check64("rsp_hold_err", {63'd0, rsp_err}, {63'd0, p_err});
                end
            end
            if (rsp_valid) begin
                check64("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
                if (!(p_valid && !p_ready)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h with no request outstanding", rsp_rdata);
                    end else begin
                        check64("rsp_latency", 64'(cyc + 1 - int'(exp_q[0].acc)), 64'(exp_q[0].lat + 32'd1));
                    end
                end
                if (rsp_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check64("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                    if (e.known) check64("rsp_rdata", rsp_rdata, e.rdata);
                    last_hs    = cyc + 1;
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                end
            end
        end
        p_valid = rsp_valid && !rst;
        p_ready = rsp_ready;
        p_rdata = rsp_rdata;
        p_err   = rsp_err;
    end

    task automatic do_req(input logic [63:0] a, input logic w, input logic [1:0] sz,
                          input logic [63:0] wd, input logic [7:0] ws, input bit track, output int acc);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        req_addr  = a;
        req_wen   = w;
        req_size  = sz;
        req_wdata = wd;
        req_wstrb = ws;
        req_valid = 1'b1;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: request to %h not accepted within 300 cycles", a);
            acc = -1;
        end else if (track) begin
            e = model_access(a, w, sz, wd, ws);
            e.acc = 32'(acc);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses still outstanding", exp_q.size());
        end
    endtask

    task automatic init_region();
        int acc;
        for (int i = 0; i < 8; i++) begin
            do_req(BASE + 64'(i) * 64'd8, 1'b1, 2'd3, {$urandom, $urandom}, 8'hFF, 1'b1, acc);
        end
        do_req(BASE + 64'(DEPTH - 1) * 64'd8, 1'b1, 2'd3, {$urandom, $urandom}, 8'hFF, 1'b1, acc);
    endtask

    task automatic rand_op();
        logic [63:0] a;
        logic [1:0]  sz;
        int          r, acc;
        r  = $urandom_range(0, 9);
        sz = 2'($urandom_range(0, 3));
        if (r == 0)      a = BASE - 64'd8 + 64'($urandom_range(0, 7));
        else if (r == 1) a = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 15));
        else if (r == 2) a = BASE + 64'(DEPTH - 1) * 64'd8 + 64'($urandom_range(0, 7));
        else             a = BASE + 64'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
        do_req(a, 1'($urandom_range(0, 1)), sz, {$urandom, $urandom}, 8'($urandom), 1'b1, acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, acc, prev, n;
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
        req_size = 2'd0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check64("reset_req_ready", {63'd0, rdy2}, 64'd1);
        check64("reset_rsp_valid", {63'd0, val2}, 64'd0);
        check64("reset_rsp_rdata", rd2, 64'd0);
        check64("reset_rsp_err", {63'd0, er2}, 64'd0);
        check64("reset_req_ready_l0", {63'd0, rdy0}, 64'd1);
        check64("reset_rsp_valid_l0", {63'd0, val0}, 64'd0);
        rst = 1'b0;

        // LAT=2 directed sequence.
        rdy_mode = 1;
        do_req(64'h8000_0010, 1'b1, 2'd3, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, a1);
        do_req(64'h8000_0010, 1'b0, 2'd3, 64'd0, 8'h00, 1'b1, a2);
        check64("throughput_l2", 64'(a2 - a1), 64'd4);
        drain();
        check64("load_dword", last_rdata, 64'h1122_3344_5566_7788);
        do_req(64'h8000_0013, 1'b1, 2'd0, 64'h0000_0000_AB00_0000, 8'h08, 1'b1, acc);
        do_req(64'h8000_0010, 1'b0, 2'd3, 64'd0, 8'h00, 1'b1, acc);
        drain();
        check64("load_after_byte_store", last_rdata, 64'h1122_3344_AB66_7788);
        do_req(64'h8000_0011, 1'b0, 2'd1, 64'd0, 8'h00, 1'b1, acc);
        drain();
        check64("misaligned_err", {63'd0, last_err}, 64'd1);
        check64("misaligned_rdata", last_rdata, 64'd0);
        do_req(64'h8000_0010, 1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, acc);
        do_req(64'h8000_0010, 1'b0, 2'd3, 64'd0, 8'h00, 1'b1, acc);
        drain();
        check64("unchanged_after_err_and_zero_strobe", last_rdata, 64'h1122_3344_AB66_7788);
        do_req(64'h7FFF_FFF8, 1'b0, 2'd3, 64'd0, 8'h00, 1'b1, acc);
        drain();
        check64("below_base_err", {63'd0, last_err}, 64'd1);

        // Response held with rsp_ready low while a second request waits.
        rdy_mode = 0;
        do_req(64'h8000_0010, 1'b0, 2'd3, 64'd0, 8'h00, 1'b1, acc);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check64("hold_reached_resp", {63'd0, rsp_valid}, 64'd1);
        req_addr = 64'h8000_0018; req_wen = 1'b1; req_size = 2'd3;
        req_wdata = 64'hCAFE_F00D_0000_0001; req_wstrb = 8'hFF; req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #2;
            check64("hold_req_ready", {63'd0, req_ready}, 64'd0);
            check64("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        end
        @(negedge clk);
        rdy_mode = 1;
        do_req(64'h8000_0018, 1'b1, 2'd3, 64'hCAFE_F00D_0000_0001, 8'hFF, 1'b1, acc);
        check64("accept_after_handshake", 64'(acc), 64'(last_hs + 1));
        drain();

        // Reset during WAIT discards the in-flight store.
        do_req(64'h8000_0020, 1'b1, 2'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, acc);
        drain();
        do_req(64'h8000_0020, 1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check64("rst_wait_req_ready", {63'd0, req_ready}, 64'd1);
        check64("rst_wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check64("rst_wait_rsp_rdata", rsp_rdata, 64'd0);
        rst = 1'b0;
        do_req(64'h8000_0020, 1'b0, 2'd3, 64'd0, 8'h00, 1'b1, acc);
        drain();
        check64("store_discarded_by_reset", last_rdata, 64'h0123_4567_89AB_CDEF);

        // LAT=2 random traffic with random response backpressure.
        rdy_mode = 2;
        init_region();
        repeat (40) rand_op();
        drain();

        // LAT=0: back-to-back loads, then random traffic.
        @(negedge clk);
        sel = 1'b1;
        rdy_mode = 1;
        init_region();
        drain();
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            do_req(BASE + 64'(k) * 64'd8, 1'b0, 2'd3, 64'd0, 8'h00, 1'b1, acc);
            if (k > 0) check64("throughput_l0", 64'(acc - prev), 64'd2);
            prev = acc;
        end
        drain();
        rdy_mode = 2;
        repeat (40) rand_op();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
